// File: rtl/act_skew_stager_pkg.sv
// Shared types and sizing for the activation skew stager.
// Provides array geometry defaults and the stager FSM encoding.
package act_skew_stager_pkg;

  localparam int MUL_SIZE  = 4;
  localparam int ACT_WIDTH = 7;

  typedef enum logic [1:0] {
    STG_IDLE,
    STG_STREAM,
    STG_DRAIN
  } stager_state_t;

  function automatic int drain_cnt_w(int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/act_skew_stager_if.sv
// Upstream valid/ready bus carrying one activation vector per beat.
// master: unified_buffer side (valid, last, data); slave: stager (ready).
interface act_skew_stager_if
  import act_skew_stager_pkg::*;
#(
  parameter int ROWS  = MUL_SIZE,
  parameter int ACT_W = ACT_WIDTH + 1
);

  logic                       valid;
  logic                       last;
  logic [ROWS-1:0][ACT_W-1:0] data;
  logic                       ready;

  modport master (
    output valid,
    output last,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  last,
    input  data,
    output ready
  );

endinterface

// File: rtl/act_skew_stager_skew_delay_line.sv
// One lane of the skew: DEPTH-stage data+valid shift register.
// Ports: clk_i, rst_i (async low), en_i, d_i/v_i in, q_o/vq_o out.
module skew_delay_line #(
  parameter int DEPTH     = 1,
  parameter int W         = 8,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] q_o,
  output logic         vq_o
);

  logic [DEPTH-1:0][W-1:0] st;
  logic [DEPTH-1:0]        vs;
  logic [W-1:0]            head;

  // Bubbles either inject zeros or repeat the last loaded value.
  always_comb begin
    head = d_i;
    if (!v_i) begin
      head = ZERO_FILL ? '0 : st[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st <= '0;
      vs <= '0;
    end else if (en_i) begin
      st[0] <= head;
      vs[0] <= v_i;
      for (int i = 1; i < DEPTH; i++) begin
        st[i] <= st[i-1];
        vs[i] <= vs[i-1];
      end
    end
  end

  assign q_o  = st[DEPTH-1];
  assign vq_o = vs[DEPTH-1];

endmodule

// File: rtl/act_skew_stager.sv
// Skews a ROWS-wide activation vector into a systolic wavefront.
// Ports: clk_i, rst_i, up (slave bus), stall_i, data_o, lane_valid_o, busy_o, drain_done_o.
module act_skew_stager
  import act_skew_stager_pkg::*;
#(
  parameter int ROWS      = MUL_SIZE,
  parameter int ACT_W     = ACT_WIDTH + 1,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  act_skew_stager_if.slave           up,
  input  logic                       stall_i,
  output logic [ROWS-1:0][ACT_W-1:0] data_o,
  output logic [ROWS-1:0]            lane_valid_o,
  output logic                       busy_o,
  output logic                       drain_done_o
);

  localparam int CW = drain_cnt_w(ROWS);

  stager_state_t state;
  stager_state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          advance;
  logic          accept;

  assign advance  = !stall_i;
  assign up.ready = advance && (state != STG_DRAIN);
  assign accept   = up.valid && up.ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH     (r + 1),
      .W         (ACT_W),
      .ZERO_FILL (ZERO_FILL)
    ) u_line (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (advance),
      .d_i   (up.data[r]),
      .v_i   (accept),
      .q_o   (data_o[r]),
      .vq_o  (lane_valid_o[r])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= STG_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (advance) begin
      unique case (state)
        STG_IDLE, STG_STREAM: begin
          if (accept) begin
            if (up.last) begin
              state_nxt = STG_DRAIN;
              cnt_nxt   = CW'(ROWS);
            end else begin
              state_nxt = STG_STREAM;
            end
          end
        end
        STG_DRAIN: begin
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = STG_IDLE;
          end
        end
        default: begin
          state_nxt = STG_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The final drain advance is when lane ROWS-1 shows the last vector.
  always_comb begin
    busy_o       = (state != STG_IDLE);
    drain_done_o = (state == STG_DRAIN) && advance && (cnt == CW'(1));
  end

endmodule

// File: tb/tb_act_skew_stager.sv
// Randomised + directed bench for act_skew_stager against a history model.
// Covers ZERO_FILL=1/0 at ROWS=4 and a directed ROWS=1 instance.
module tb_act_skew_stager;

  localparam int R = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  act_skew_stager_if #(.ROWS(R), .ACT_W(W)) if_a ();
  act_skew_stager_if #(.ROWS(R), .ACT_W(W)) if_b ();
  act_skew_stager_if #(.ROWS(1), .ACT_W(W)) if_c ();

  logic [R-1:0][W-1:0] d_a, d_b;
  logic [R-1:0]        lv_a, lv_b;
  logic                busy_a, busy_b, dd_a, dd_b;
  logic [0:0][W-1:0]   d_c;
  logic [0:0]          lv_c;
  logic                busy_c, dd_c;

  act_skew_stager #(.ROWS(R), .ACT_W(W), .ZERO_FILL(1'b1)) u_zf1 (
    .clk_i(clk), .rst_i(rst_n), .up(if_a), .stall_i(stall),
    .data_o(d_a), .lane_valid_o(lv_a), .busy_o(busy_a),
    .drain_done_o(dd_a)
  );

  act_skew_stager #(.ROWS(R), .ACT_W(W), .ZERO_FILL(1'b0)) u_zf0 (
    .clk_i(clk), .rst_i(rst_n), .up(if_b), .stall_i(stall),
    .data_o(d_b), .lane_valid_o(lv_b), .busy_o(busy_b),
    .drain_done_o(dd_b)
  );

  act_skew_stager #(.ROWS(1), .ACT_W(W), .ZERO_FILL(1'b1)) u_r1 (
    .clk_i(clk), .rst_i(rst_n), .up(if_c), .stall_i(stall),
    .data_o(d_c), .lane_valid_o(lv_c), .busy_o(busy_c),
    .drain_done_o(dd_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: every advancing cycle pushes what stage 0 received;
  // lane r shows the entry pushed r advances before the newest.
  typedef struct {
    logic [31:0] z;
    logic [31:0] h;
    bit          v;
  } ent_t;

  ent_t        hist[$];
  logic [31:0] held;
  int          last_age;
  bit          stream;
  logic        s_dd;
  logic [31:0] s_d;

  function automatic void m_reset();
    hist.delete();
    held     = '0;
    last_age = -1;
    stream   = 1'b0;
  endfunction

  function automatic bit m_drain();
    return (last_age >= 0) && (last_age < R);
  endfunction

  function automatic logic [31:0] m_data(bit hold);
    logic [31:0] e = '0;
    for (int r = 0; r < R; r++) begin
      int idx = hist.size() - 1 - r;
      if (idx >= 0) begin
        e[r*W +: W] = hold ? hist[idx].h[r*W +: W]
                           : hist[idx].z[r*W +: W];
      end
    end
    return e;
  endfunction

  function automatic logic [R-1:0] m_valid();
    logic [R-1:0] e = '0;
    for (int r = 0; r < R; r++) begin
      int idx = hist.size() - 1 - r;
      if (idx >= 0) e[r] = hist[idx].v;
    end
    return e;
  endfunction

  task automatic do_cycle(input bit v, input bit l,
                          input logic [31:0] d, input bit s);
    bit   acc;
    bit   drn;
    ent_t e;
    @(negedge clk);
    if_a.valid = v; if_a.last = l; if_a.data = d;
    if_b.valid = v; if_b.last = l; if_b.data = d;
    stall = s;
    #1;
    drn = m_drain();
    s_dd = dd_a;
    s_d  = d_a;
    chk("data_zf1", d_a, m_data(1'b0));
    chk("lv_zf1", lv_a, m_valid());
    chk("data_zf0", d_b, m_data(1'b1));
    chk("lv_zf0", lv_b, m_valid());
    chk("busy", busy_a, stream || drn);
    chk("busy_zf0", busy_b, stream || drn);
    chk("ready", if_a.ready, !s && !drn);
    chk("ready_zf0", if_b.ready, !s && !drn);
    chk("done", dd_a, drn && (last_age == R - 1) && !s);
    chk("done_zf0", dd_b, drn && (last_age == R - 1) && !s);
    @(posedge clk);
    if (!s) begin
      acc = v && !drn;
      if (acc) begin
        held = d;
        e.z = d;
        e.h = d;
      end else begin
        e.z = '0;
        e.h = held;
      end
      e.v = acc;
      hist.push_back(e);
      if (hist.size() > R) void'(hist.pop_front());
      if (last_age >= 0 && last_age < 1000) last_age++;
      if (acc && l) begin
        last_age = 0;
        stream   = 1'b0;
      end else if (acc) begin
        stream = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    if_a.valid = 1'b0; if_a.last = 1'b0; if_a.data = '0;
    if_b.valid = 1'b0; if_b.last = 1'b0; if_b.data = '0;
    if_c.valid = 1'b0; if_c.last = 1'b0; if_c.data = '0;
    m_reset();
    #12;
    chk("rst_data", d_a, 32'h0);
    chk("rst_lv", lv_a, 4'h0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", dd_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back vectors, last on the second.
    do_cycle(1'b1, 1'b0, 32'h04030201, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h08070605, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    chk("tp1_l0_c2", s_d[7:0], 8'd5);
    idle(2);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    chk("tp1_done_c5", s_dd, 1'b1);
    chk("tp1_l3_c5", s_d[31:24], 8'd8);
    idle(2);

    // Single vector with last, then a stalled drain.
    do_cycle(1'b1, 1'b1, 32'h09090909, 1'b0);
    idle(3);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    chk("tp2_done_c4", s_dd, 1'b1);
    chk("tp2_l3_c4", s_d[31:24], 8'd9);
    do_cycle(1'b1, 1'b1, 32'h0d0c0b0a, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'hffffffff, 1'b1);
    idle(4);

    // Bubble between vectors.
    do_cycle(1'b1, 1'b0, 32'h11121314, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h21222324, 1'b0);
    idle(6);

    // Async reset mid-drain.
    do_cycle(1'b1, 1'b1, 32'h31323334, 1'b0);
    do_cycle(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    if_a.valid = 1'b0; if_b.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", d_a, 32'h0);
    chk("arst_lv", lv_a, 4'h0);
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_done", dd_a, 1'b0);
    chk("arst_data_zf0", d_b, 32'h0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_cycle(1'b1, 1'b0, 32'h41424344, 1'b0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
               $urandom, $urandom_range(0, 9) < 2);
    end
    idle(6);

    // ROWS=1 instance: stray last, then a one-vector tile.
    @(negedge clk);
    if_c.valid = 1'b0; if_c.last = 1'b1; if_c.data = 8'h55;
    #1 chk("r1_ready_idle", if_c.ready, 1'b1);
    @(negedge clk);
    if_c.last = 1'b0;
    #1;
    chk("r1_stray_busy", busy_c, 1'b0);
    chk("r1_stray_lv", lv_c, 1'b0);
    if_c.valid = 1'b1; if_c.last = 1'b1; if_c.data = 8'h07;
    @(negedge clk);
    if_c.valid = 1'b0; if_c.last = 1'b0;
    #1;
    chk("r1_data", d_c, 8'h07);
    chk("r1_lv", lv_c, 1'b1);
    chk("r1_done", dd_c, 1'b1);
    chk("r1_ready_drain", if_c.ready, 1'b0);
    chk("r1_busy", busy_c, 1'b1);
    @(negedge clk);
    #1;
    chk("r1_idle_busy", busy_c, 1'b0);
    chk("r1_idle_done", dd_c, 1'b0);
    chk("r1_idle_lv", lv_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
